// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states, datapath width and the fixed accept-to-done latency.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_LAT   = 34;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } mdu_state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the ALU issue logic and the multiply/divide
// unit; the master issues operations, the slave returns hi/lo results.
interface mult_div_unit_if #(
  parameter int WIDTH = mdu_pkg::MDU_WIDTH
);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             hi_en;
  logic             lo_en;

  modport master (
    output start, op, a, b,
    input  busy, done, hi_out, lo_out, hi_en, lo_en
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi_out, lo_out, hi_en, lo_en
  );

endinterface

// File: rtl/mdu_neg.sv
// Conditional two's-complement: passes din through, or negates it when neg=1.
module mdu_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-cycle shift-add multiplier / restoring divider working on
// operand magnitudes, with a one-cycle sign fix-up and registered hi/lo results.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  mult_div_unit_if.slave bus
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  mdu_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               sgn_op;
  logic               sgn_diff;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] div_next;

  assign sgn_op   = op_is_signed(bus.op);
  assign sgn_diff = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];

  mdu_neg #(.W(WIDTH)) u_neg_a (.din(bus.a), .neg(sgn_op & bus.a[WIDTH-1]), .dout(a_mag));
  mdu_neg #(.W(WIDTH)) u_neg_b (.din(bus.b), .neg(sgn_op & bus.b[WIDTH-1]), .dout(b_mag));

  mdu_neg #(.W(2*WIDTH)) u_neg_prod (.din(acc_q), .neg(neg_res_q), .dout(prod_fix));
  mdu_neg #(.W(WIDTH)) u_neg_quo (.din(acc_q[WIDTH-1:0]), .neg(neg_res_q), .dout(quo_fix));
  mdu_neg #(.W(WIDTH)) u_neg_rem (.din(acc_q[2*WIDTH-1:WIDTH]), .neg(neg_rem_q), .dout(rem_fix));

  // acc holds {partial product | remainder, multiplier | dividend/quotient};
  // the remainder step compares a WIDTH+1 bit shifted partial remainder.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opb_q};
    div_sub   = div_shift[WIDTH-1:0] - opb_q;
    div_next  = {div_ge ? div_sub : div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    opb_d     = opb_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = CALC;
          cnt_d     = CNT_LOAD;
          op_d      = bus.op;
          opb_d     = b_mag;
          acc_d     = {{WIDTH{1'b0}}, a_mag};
          // A zero divisor keeps the all-ones quotient unsigned.
          neg_res_d = sgn_op & sgn_diff & (!op_is_div(bus.op) | (bus.b != '0));
          neg_rem_d = sgn_op & bus.a[WIDTH-1];
          busy_d    = 1'b1;
        end
      end
      CALC: begin
        acc_d = op_is_div(op_q) ? div_next : mul_next;
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FIX: begin
        state_d = DONE;
        done_d  = 1'b1;
        if (op_is_div(op_q)) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      opb_q     <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      opb_q     <= opb_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.hi_en  = done_q;
  assign bus.lo_en  = done_q;
  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: accepted requests push a reference
// result computed with plain 64-bit arithmetic; a monitor checks every cycle.
module tb_mult_div_unit;
  import mdu_pkg::*;

  typedef struct {
    logic [63:0] res;
    int          acc_edge;
  } exp_t;

  logic clk;
  logic rst;

  mult_div_unit_if bus ();

  mult_div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sboard[$];
  int   n_vec     = 0;
  int   n_err     = 0;
  int   edge_cnt  = 0;
  int   last_acc  = 0;
  bit   active    = 0;
  logic exp_busy;
  logic exp_done;
  exp_t popped;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sbv, q, r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (op)
      OP_MULTU: return {32'h0, a} * {32'h0, b};
      OP_MULT:  return 64'(sa * sbv);
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (op == OP_DIVU) return {a % b, a / b};
        q = sa / sbv;
        r = sa % sbv;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Acceptance model: a request is taken on an edge where start is high and
  // the previous operation has fully retired (35-cycle throughput).
  always @(posedge clk) begin
    edge_cnt++;
    if (!rst) begin
      active = 0;
      sboard.delete();
    end else if (bus.start && (!active || edge_cnt >= last_acc + MDU_LAT + 1)) begin
      active   = 1;
      last_acc = edge_cnt;
      sboard.push_back('{res: ref_model(bus.op, bus.a, bus.b), acc_edge: edge_cnt});
    end
  end

  // Monitor: busy/done/strobes every cycle, results popped on done.
  always @(negedge clk) begin
    if (rst) begin
      exp_busy = active && (edge_cnt <= last_acc + MDU_LAT - 1);
      exp_done = active && (edge_cnt == last_acc + MDU_LAT - 1);
      checkOutput("busy", 64'(bus.busy), 64'(exp_busy));
      checkOutput("done", 64'(bus.done), 64'(exp_done));
      checkOutput("hi_en", 64'(bus.hi_en), 64'(exp_done));
      checkOutput("lo_en", 64'(bus.lo_en), 64'(exp_done));
      if (bus.done) begin
        if (sboard.size() == 0) begin
          n_vec++;
          n_err++;
          $display("[TB] FAIL unexpected_done: got done=1, expected no pending result (t=%0t)", $time);
        end else begin
          popped = sboard.pop_front();
          checkOutput("hi_out", 64'(bus.hi_out), 64'(popped.res[63:32]));
          checkOutput("lo_out", 64'(bus.lo_out), 64'(popped.res[31:0]));
          checkOutput("latency", 64'(edge_cnt - popped.acc_edge + 1), 64'(MDU_LAT));
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic scramble_inputs();
    bus.op = 2'($urandom_range(0, 3));
    bus.a  = $urandom;
    bus.b  = $urandom;
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_busy"}, 64'(bus.busy), 64'(0));
    checkOutput({tag, "_done"}, 64'(bus.done), 64'(0));
    checkOutput({tag, "_hi_en"}, 64'(bus.hi_en), 64'(0));
    checkOutput({tag, "_lo_en"}, 64'(bus.lo_en), 64'(0));
    checkOutput({tag, "_hi_out"}, 64'(bus.hi_out), 64'(0));
    checkOutput({tag, "_lo_out"}, 64'(bus.lo_out), 64'(0));
  endtask

  // One-cycle start pulse, then wait until the unit is idle again.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    step();
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    step();
    bus.start = 1'b0;
    scramble_inputs();
    repeat (MDU_LAT + 1) step();
  endtask

  initial begin
    #500000;
    n_err++;
    $display("[TB] FAIL global_timeout: got no completion, expected finish before 500us");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = 32'h0;
    bus.b     = 32'h0;
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b1;
    step();

    $display("[TB] directed operations");
    applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus(OP_MULT,  32'hFFFF_FFFD, 32'd7);
    applyStimulus(OP_DIV,   32'hFFFF_FFF9, 32'd2);
    applyStimulus(OP_DIVU,  32'd100, 32'd7);
    applyStimulus(OP_DIVU,  32'd100, 32'd0);
    applyStimulus(OP_DIV,   32'hFFFF_FFF9, 32'd0);
    applyStimulus(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    applyStimulus(OP_MULT,  32'h8000_0000, 32'h8000_0000);

    $display("[TB] start pulses while busy");
    step();
    bus.start = 1'b1;
    bus.op    = OP_MULTU;
    bus.a     = 32'd1234;
    bus.b     = 32'd5678;
    step();
    bus.start = 1'b0;
    repeat (4) step();
    bus.start = 1'b1;
    scramble_inputs();
    step();
    bus.start = 1'b0;
    repeat (14) step();
    bus.start = 1'b1;
    scramble_inputs();
    step();
    bus.start = 1'b0;
    repeat (MDU_LAT) step();

    $display("[TB] start held high");
    bus.start = 1'b1;
    for (int i = 0; i < 110; i++) begin
      scramble_inputs();
      step();
    end
    bus.start = 1'b0;
    repeat (MDU_LAT + 6) step();

    $display("[TB] reset mid-operation");
    step();
    bus.start = 1'b1;
    bus.op    = OP_MULT;
    bus.a     = 32'hFFFF_0001;
    bus.b     = 32'd99;
    step();
    bus.start = 1'b0;
    repeat (9) step();
    rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) step();
    rst = 1'b1;
    applyStimulus(OP_MULTU, 32'd3, 32'd5);

    $display("[TB] random operations");
    for (int i = 0; i < 30; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), rand_word(), rand_word());
    end

    repeat (5) step();
    checkOutput("scoreboard_empty", 64'(sboard.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
